sort_feeder: RTL and testbench

- Upstream stage of the packet sorter.
- Accepts words on a ready/valid stream with a `last` marker and buffers one whole packet of up to 2**AWIDTH words.
- Replays the packet to the sorter as a contiguous sop/val/eop burst, but only while the sorter reports not busy.
- Truncates over-length packets and discards their remainder, so the sorter never receives more words than its memory holds.

---
 rtl/sort_pkg.sv | 14 +
 rtl/sort_feeder_buf.sv | 25 ++
 rtl/sort_feeder.sv | 156 +++++++++++++++
 tb/tb_sort_feeder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and constants for the sort feeder.
package sort_pkg;

    typedef enum logic [2:0] {IDLE, FILL, DROP, WAIT, SEND, GAP} state_t;

    function automatic int max_len(input int awidth);
        return 1 << awidth;
    endfunction

    localparam int DEF_AWIDTH = 3;
    localparam int MAX_LEN    = max_len(DEF_AWIDTH);
    localparam int STATS_W    = 16;

endpackage

// File: rtl/sort_feeder_buf.sv
// rtl/sort_feeder_buf.sv - simple dual-port packet buffer, synchronous read.
module sort_feeder_buf
    import sort_pkg::*;
#(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem [max_len(AWIDTH)];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sort_feeder.sv
// rtl/sort_feeder.sv - buffers one packet and replays it to the sorter as a sop/val/eop burst.
// Optional SORT_FEEDER_STATS_EN adds saturating packet and truncation counters.
module sort_feeder
    import sort_pkg::*;
#(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              last_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              busy_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              val_o,
    output logic              trunc_o
`ifdef SORT_FEEDER_STATS_EN
    ,
    output logic [STATS_W-1:0] pkt_cnt_o,
    output logic [STATS_W-1:0] trunc_cnt_o
`endif
);

    localparam logic [AWIDTH:0] MAX_CNT = (AWIDTH+1)'(max_len(AWIDTH));

    state_t            state;
    logic [AWIDTH:0]   wr_cnt;
    logic [AWIDTH:0]   rd_cnt;
    logic [AWIDTH:0]   len;
    logic              iss_v;
    logic              iss_sop;
    logic              iss_eop;
    logic              accept;
    logic              wr_en;
    logic [DWIDTH-1:0] rd_data;

    assign accept = valid_i && ready_o;
    assign wr_en  = accept && (state == IDLE || state == FILL);

    sort_feeder_buf #(
        .AWIDTH(AWIDTH),
        .DWIDTH(DWIDTH)
    ) u_buf (
        .clk     (clk_i),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt[AWIDTH-1:0]),
        .wr_data (data_i),
        .rd_addr (rd_cnt[AWIDTH-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state   <= IDLE;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            len     <= '0;
            ready_o <= 1'b1;
            iss_v   <= 1'b0;
            iss_sop <= 1'b0;
            iss_eop <= 1'b0;
            val_o   <= 1'b0;
            sop_o   <= 1'b0;
            eop_o   <= 1'b0;
            trunc_o <= 1'b0;
            data_o  <= '0;
        end else begin
            trunc_o <= 1'b0;
            case (state)
                IDLE, FILL: begin
                    if (accept) begin
                        if (last_i) begin
                            state   <= WAIT;
                            len     <= wr_cnt + 1'b1;
                            wr_cnt  <= '0;
                            ready_o <= 1'b0;
                        end else if (wr_cnt == MAX_CNT - 1'b1) begin
                            state   <= DROP;
                            len     <= MAX_CNT;
                            wr_cnt  <= '0;
                            trunc_o <= 1'b1;
                        end else begin
                            state  <= FILL;
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (accept && last_i) begin
                        state   <= WAIT;
                        ready_o <= 1'b0;
                    end
                end
                WAIT: begin
                    if (!busy_i) begin
                        state  <= SEND;
                        rd_cnt <= '0;
                    end
                end
                SEND: begin
                    // Issue stage runs one cycle ahead of the output stage to cover the RAM read latency.
                    if (rd_cnt != len) begin
                        iss_v   <= 1'b1;
                        iss_sop <= (rd_cnt == '0);
                        iss_eop <= (rd_cnt == len - 1'b1);
                        rd_cnt  <= rd_cnt + 1'b1;
                    end else begin
                        iss_v   <= 1'b0;
                        iss_sop <= 1'b0;
                        iss_eop <= 1'b0;
                    end
                    val_o  <= iss_v;
                    sop_o  <= iss_sop;
                    eop_o  <= iss_eop;
                    data_o <= iss_v ? rd_data : '0;
                    if (eop_o) begin
                        state  <= GAP;
                        val_o  <= 1'b0;
                        sop_o  <= 1'b0;
                        eop_o  <= 1'b0;
                        data_o <= '0;
                    end
                end
                GAP: begin
                    state   <= FILL;
                    ready_o <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

`ifdef SORT_FEEDER_STATS_EN
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            pkt_cnt_o   <= '0;
            trunc_cnt_o <= '0;
        end else begin
            if (state == SEND && eop_o && pkt_cnt_o != '1) begin
                pkt_cnt_o <= pkt_cnt_o + 1'b1;
            end
            if (trunc_o && trunc_cnt_o != '1) begin
                trunc_cnt_o <= trunc_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sort_feeder.sv
// tb/tb_sort_feeder.sv - scoreboard bench for sort_feeder with directed packets.
module tb_sort_feeder;

    logic       clk = 1'b0;
    logic       srst_i;
    logic [7:0] data_i;
    logic       last_i;
    logic       valid_i;
    logic       ready_o;
    logic       busy_i;
    logic [7:0] data_o;
    logic       sop_o;
    logic       eop_o;
    logic       val_o;
    logic       trunc_o;
`ifdef SORT_FEEDER_STATS_EN
    logic [15:0] pkt_cnt_o;
    logic [15:0] trunc_cnt_o;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    int         trunc_seen = 0;
    int         st;
    int         st2;
    int         tr_before;
    logic [9:0] exp_q[$];
    logic [9:0] e;
    logic [7:0] pkt[16];

    always #5 clk = ~clk;

    sort_feeder #(.AWIDTH(3), .DWIDTH(8)) dut (
        .clk_i   (clk),
        .srst_i  (srst_i),
        .data_i  (data_i),
        .last_i  (last_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .busy_i  (busy_i),
        .data_o  (data_o),
        .sop_o   (sop_o),
        .eop_o   (eop_o),
        .val_o   (val_o),
        .trunc_o (trunc_o)
`ifdef SORT_FEEDER_STATS_EN
        ,
        .pkt_cnt_o   (pkt_cnt_o),
        .trunc_cnt_o (trunc_cnt_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented word is matched against the scoreboard head.
    always @(negedge clk) begin
        if (trunc_o === 1'b1) trunc_seen++;
        if (val_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h with nothing expected", data_o);
            end else begin
                e = exp_q.pop_front();
                chk("burst_word", 32'({data_o, sop_o, eop_o}), 32'(e));
            end
        end
    end

    task automatic send_pkt(input int n, output int stalls);
        int m;
        int guard;
        logic acc;
        m = (n > 8) ? 8 : n;
        for (int i = 0; i < m; i++) exp_q.push_back({pkt[i], i == 0, i == m - 1});
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            data_i  = pkt[i];
            last_i  = (i == n - 1);
            valid_i = 1'b1;
            guard   = 0;
            forever begin
                @(negedge clk);
                acc = ready_o;
                @(posedge clk);
                #1;
                if (acc) break;
                stalls++;
                guard++;
                if (guard > 300) begin
                    chk("accept_timeout", 32'd1, 32'd0);
                    break;
                end
            end
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic drain(input bit gap_check);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        if (k == 300) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        if (gap_check) begin
            @(negedge clk);
            chk("gap_val", 32'(val_o), 32'd0);
            chk("gap_ready", 32'(ready_o), 32'd0);
            @(negedge clk);
            chk("post_gap_ready", 32'(ready_o), 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        srst_i  = 1'b1;
        data_i  = '0;
        last_i  = 1'b0;
        valid_i = 1'b0;
        busy_i  = 1'b0;
        #12;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_val", 32'({val_o, sop_o, eop_o, trunc_o}), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
`ifdef SORT_FEEDER_STATS_EN
        chk("rst_stats", 32'({pkt_cnt_o, trunc_cnt_o}), 32'd0);
`endif
        #10 srst_i = 1'b0;
        @(posedge clk);
        #1;

        // Nominal 5-word packet
        pkt[0] = 8'h30; pkt[1] = 8'h10; pkt[2] = 8'h50; pkt[3] = 8'h20; pkt[4] = 8'h40;
        send_pkt(5, st);
        chk("nominal_stalls", 32'(st), 32'd0);
        drain(1'b1);

        // Backpressure: packet waits while busy, second packet held until GAP ends
        busy_i = 1'b1;
        pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h03;
        send_pkt(3, st);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_ready", 32'(ready_o), 32'd0);
            chk("wait_val", 32'(val_o), 32'd0);
        end
        @(posedge clk);
        #1;
        pkt[0] = 8'h61; pkt[1] = 8'h62;
        fork
            send_pkt(2, st2);
            begin
                busy_i = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("lat_cycle1", 32'(val_o), 32'd0);
                @(negedge clk);
                chk("lat_cycle2", 32'(val_o), 32'd0);
                @(negedge clk);
                chk("lat_cycle3", 32'(val_o), 32'd1);
            end
        join
        chk("held_stalls", 32'(st2), 32'd7);
        drain(1'b1);

        // Truncation: 11 words, first 8 kept
        for (int i = 0; i < 11; i++) pkt[i] = 8'h80 + 8'(i);
        tr_before = trunc_seen;
        send_pkt(11, st);
        chk("trunc_stalls", 32'(st), 32'd0);
        drain(1'b1);
        chk("trunc_pulses", 32'(trunc_seen - tr_before), 32'd1);

        // Exact fit: 8 words with last on word 8
        for (int i = 0; i < 8; i++) pkt[i] = 8'hC0 + 8'(i);
        tr_before = trunc_seen;
        send_pkt(8, st);
        drain(1'b1);
        chk("exact_no_trunc", 32'(trunc_seen - tr_before), 32'd0);

        // Single word
        pkt[0] = 8'hAA;
        send_pkt(1, st);
        drain(1'b1);

        // Async reset in the middle of a burst
        for (int i = 0; i < 6; i++) pkt[i] = 8'hD0 + 8'(i);
        send_pkt(6, st);
        begin
            int k;
            for (k = 0; k < 50; k++) begin
                @(negedge clk);
                if (val_o) break;
            end
            if (k == 50) chk("send_start_timeout", 32'd1, 32'd0);
        end
        #2 srst_i = 1'b1;
        #1;
        chk("arst_val", 32'({val_o, sop_o, eop_o}), 32'd0);
        chk("arst_data", 32'(data_o), 32'd0);
        chk("arst_ready", 32'(ready_o), 32'd1);
`ifdef SORT_FEEDER_STATS_EN
        chk("arst_stats", 32'({pkt_cnt_o, trunc_cnt_o}), 32'd0);
`endif
        exp_q.delete();
        @(posedge clk);
        #2 srst_i = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(ready_o), 32'd1);
        pkt[0] = 8'hE0; pkt[1] = 8'hE1; pkt[2] = 8'hE2;
        send_pkt(3, st);
        drain(1'b1);
`ifdef SORT_FEEDER_STATS_EN
        chk("stats_pkt", 32'(pkt_cnt_o), 32'd1);
        chk("stats_trunc", 32'(trunc_cnt_o), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
